digit_entry_reg: RTL and testbench
==================================

# digit_entry_reg

Parametrised keypad digit-entry register. Shifts decoded BCD key codes into a DIGITS-wide display buffer, least-significant digit first. Supports clear, optional backspace, selectable overflow policy and an enter/commit path. Sits between the keypad scanner/debouncer and the seven-segment display driver / arithmetic back end, replacing the fixed two-digit shifter.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits held (≥2).
- ROLL, 0, overflow policy:
  - 0 = saturate: reject keys when full.
  - 1 = roll: discard the MSD and accept.
- CW, $clog2(DIGITS+1), width of `count` (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  key code present this cycle.
- key_in  in  4  key code; 0–9 are digits, 10–15 are illegal.
- key_ready  out  1  block accepts a key this cycle; accept = key_valid & key_ready.
- clr  in  1  strobe: clear buffer.
- bksp  in  1  strobe: delete LSD (only when DIGIT_ENTRY_BKSP_EN is defined).
- enter  in  1  strobe: commit buffer.
- digits  out  4*DIGITS  live buffer; digit i at [4i+3:4i]; digit 0 = LSD.
- count  out  CW  significant digits entered.
- full  out  1  count == DIGITS.
- err  out  1  1-cycle pulse: illegal key accepted-cycle or saturate reject.
- value  out  4*DIGITS  committed value; holds between commits.
- value_valid  out  1  1-cycle pulse after commit.

## Operation
- Event priority per cycle: rst > clr > bksp > enter > key. Only the highest-priority active event takes effect; lower events that cycle are dropped.
- key_ready = ~full | ROLL. It is combinational from registered state only.
- Accepted legal key (0–9):
  - If count == 0 and key_in == 0: leading zero. Buffer and count are unchanged; no err.
  - Otherwise: digits ← {digits[4(DIGITS-1)-1:0], key_in}, i.e. every digit shifts up one place.
  - count increments, saturating at DIGITS.
  - With ROLL=1 and full: the MSD is discarded and count stays DIGITS.
- Illegal key (10–15) with key_valid & key_ready: no state change; err pulses.
- key_valid while ~key_ready (saturate, full): no state change; err pulses.
- clr: digits ← 0 and count ← 0. value is untouched.
- bksp: digits ← {4'd0, digits[4*DIGITS-1:4]}, i.e. every digit shifts down one place. count decrements.
  - No-op when count == 0.
- enter: value ← digits; value_valid pulses. The buffer is then cleared (digits ← 0, count ← 0) in the same update.
  - enter with count == 0 commits zero.
- State: a DIGITS×4 buffer register, a CW-bit counter, a value register, and registered err / value_valid.

## Timing
- All state updates on the rising edge of clk. Outputs are registered, except key_ready.
- Latency:
  - Accepted key to digits/count/full: 1 cycle.
  - enter to value/value_valid: 1 cycle.
  - err asserts the cycle after the offending event, for exactly 1 cycle.
- Reset (rst high at an edge), as seen after that edge:
  - digits = 0, count = 0, full = 0, value = 0, err = 0, value_valid = 0.
  - key_ready = 1.
  - Reset mid-entry discards all pending digits and the committed value.
- Strobes are level-sampled each cycle. A strobe held for N cycles acts N times; upstream must pulse.
- Back-to-back keys on consecutive cycles must each be accepted, with no bubble.

## Configuration
- DIGIT_ENTRY_BKSP_EN defined: bksp is functional as above.
- Not defined: the bksp port exists but is ignored, and the priority chain skips it. No backspace logic is synthesised.

## Test plan
- DIGITS=4, ROLL=0. Reset, then keys 0,0,1,2,3,4 → digits=16'h1234, count=4, full=1. Key 5 → err pulse, digits unchanged.
- DIGITS=4, ROLL=1. Keys 1,2,3,4,5 → digits=16'h2345, count=4, no err, key_ready stays 1.
- Key 4'hB → err pulse 1 cycle later; digits and count unchanged.
- With DIGIT_ENTRY_BKSP_EN, from 16'h0123 (count=3):
  - bksp → 16'h0012, count=2.
  - Three more bksp → 16'h0000, count=0; the fourth is a no-op.
- Buffer 16'h0987, enter → next cycle value=16'h0987, value_valid=1 for one cycle, digits=0. Same-cycle clr+enter → clear only, no value_valid.
- Mid-entry rst after keys 7,8 → all outputs zero next cycle. Key 9 then gives digits=16'h0009.

Source files
------------

// File: rtl/digit_entry_reg.sv
// Keypad digit-entry register: shifts BCD keys into a DIGITS-wide buffer, LSD first.
// Define DIGIT_ENTRY_BKSP_EN to enable the backspace strobe.
module digit_entry_reg #(
    parameter int DIGITS = 4,
    parameter int ROLL   = 0,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [3:0]            key_in,
    output logic                  key_ready,
    input  logic                  clr,
    input  logic                  bksp,
    input  logic                  enter,
    output logic [4*DIGITS-1:0]   digits,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  err,
    output logic [4*DIGITS-1:0]   value,
    output logic                  value_valid
);

    localparam int W = 4 * DIGITS;
    localparam logic ROLL_EN = (ROLL != 0);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

    logic [W-1:0]  buf_q, buf_d;
    logic [W-1:0]  val_q, val_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          vv_q, vv_d;
    logic          full_q;
    logic          bksp_act;

`ifdef DIGIT_ENTRY_BKSP_EN
    assign bksp_act = bksp;
`else
    logic bksp_unused;
    assign bksp_unused = bksp;
    assign bksp_act    = 1'b0;
`endif

    assign full_q    = (cnt_q == CNT_MAX);
    assign key_ready = ~full_q | ROLL_EN;

    // Strict priority: only the highest active event updates state.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        val_d = val_q;
        err_d = 1'b0;
        vv_d  = 1'b0;
        if (clr) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (bksp_act) begin
            if (cnt_q != '0) begin
                buf_d = {4'd0, buf_q[W-1:4]};
                cnt_d = cnt_q - CW'(1);
            end
        end else if (enter) begin
            val_d = buf_q;
            vv_d  = 1'b1;
            buf_d = '0;
            cnt_d = '0;
        end else if (key_valid) begin
            if (!key_ready || key_in > 4'd9) begin
                err_d = 1'b1;
            end else if (!(cnt_q == '0 && key_in == 4'd0)) begin
                // In roll mode the shift drops the MSD once full.
                buf_d = {buf_q[W-5:0], key_in};
                if (!full_q) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
            cnt_q <= '0;
            val_q <= '0;
            err_q <= 1'b0;
            vv_q  <= 1'b0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            val_q <= val_d;
            err_q <= err_d;
            vv_q  <= vv_d;
        end
    end

    assign digits      = buf_q;
    assign count       = cnt_q;
    assign full        = full_q;
    assign err         = err_q;
    assign value       = val_q;
    assign value_valid = vv_q;

endmodule

// File: tb/tb_digit_entry_reg.sv
// Directed bench for digit_entry_reg: a saturating and a rolling instance
// share one stimulus stream and are checked against hand-computed values.
module tb_digit_entry_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_in = 4'd0;
    logic        clr = 1'b0;
    logic        bksp = 1'b0;
    logic        enter = 1'b0;

    logic        s_ready, s_full, s_err, s_vv;
    logic [15:0] s_digits, s_value;
    logic [2:0]  s_count;
    logic        r_ready, r_full, r_err, r_vv;
    logic [15:0] r_digits, r_value;
    logic [2:0]  r_count;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    digit_entry_reg #(.DIGITS(4), .ROLL(0)) u_sat (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in),
        .key_ready(s_ready), .clr(clr), .bksp(bksp), .enter(enter),
        .digits(s_digits), .count(s_count), .full(s_full), .err(s_err),
        .value(s_value), .value_valid(s_vv)
    );

    digit_entry_reg #(.DIGITS(4), .ROLL(1)) u_roll (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in),
        .key_ready(r_ready), .clr(clr), .bksp(bksp), .enter(enter),
        .digits(r_digits), .count(r_count), .full(r_full), .err(r_err),
        .value(r_value), .value_valid(r_vv)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock with the given inputs; outputs are sampled 1ns after the edge.
    task automatic drive(input logic r, input logic c, input logic b,
                         input logic e, input logic kv, input logic [3:0] k);
        rst = r; clr = c; bksp = b; enter = e; key_valid = kv; key_in = k;
        @(posedge clk);
        #1;
        rst = 0; clr = 0; bksp = 0; enter = 0; key_valid = 0; key_in = 0;
    endtask

    task automatic key(input logic [3:0] k);
        drive(0, 0, 0, 0, 1, k);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 4'd0);
    endtask

    initial begin
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 4'd0);
        check("rst_digits", 32'(s_digits), 32'h0);
        check("rst_count", 32'(s_count), 32'd0);
        check("rst_full", 32'(s_full), 32'd0);
        check("rst_value", 32'(s_value), 32'h0);
        check("rst_err", 32'(s_err), 32'd0);
        check("rst_vv", 32'(s_vv), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);

        key(0); key(0);
        check("lead0_count", 32'(s_count), 32'd0);
        check("lead0_err", 32'(s_err), 32'd0);
        key(1); key(2); key(3); key(4);
        check("sat_digits", 32'(s_digits), 32'h1234);
        check("sat_count", 32'(s_count), 32'd4);
        check("sat_full", 32'(s_full), 32'd1);
        check("sat_ready", 32'(s_ready), 32'd0);
        check("roll_ready_full", 32'(r_ready), 32'd1);

        key(5);
        check("sat_rej_err", 32'(s_err), 32'd1);
        check("sat_rej_digits", 32'(s_digits), 32'h1234);
        check("roll_digits", 32'(r_digits), 32'h2345);
        check("roll_count", 32'(r_count), 32'd4);
        check("roll_err", 32'(r_err), 32'd0);
        idle();
        check("sat_err_1cyc", 32'(s_err), 32'd0);

        key(4'hB);
        check("ill_err", 32'(r_err), 32'd1);
        check("ill_digits", 32'(r_digits), 32'h2345);
        check("ill_count", 32'(r_count), 32'd4);
        idle();
        check("ill_err_1cyc", 32'(r_err), 32'd0);

        drive(0, 1, 0, 0, 0, 4'd0);
        check("clr_digits", 32'(r_digits), 32'h0);
        check("clr_count", 32'(s_count), 32'd0);

        key(9); key(8); key(7);
        check("e_digits", 32'(s_digits), 32'h0987);
        drive(0, 0, 0, 1, 0, 4'd0);
        check("e_value", 32'(s_value), 32'h0987);
        check("e_vv", 32'(s_vv), 32'd1);
        check("e_digits_clr", 32'(s_digits), 32'h0);
        check("e_count_clr", 32'(s_count), 32'd0);
        idle();
        check("e_vv_1cyc", 32'(s_vv), 32'd0);
        check("e_value_hold", 32'(s_value), 32'h0987);

        key(5);
        drive(0, 1, 0, 1, 1, 4'd6);
        check("ce_digits", 32'(s_digits), 32'h0);
        check("ce_vv", 32'(s_vv), 32'd0);
        check("ce_value", 32'(s_value), 32'h0987);

        key(1); key(2); key(3);
        check("b_start", 32'(s_digits), 32'h0123);
`ifdef DIGIT_ENTRY_BKSP_EN
        drive(0, 0, 1, 0, 0, 4'd0);
        check("b1_digits", 32'(s_digits), 32'h0012);
        check("b1_count", 32'(s_count), 32'd2);
        drive(0, 0, 1, 0, 0, 4'd0);
        drive(0, 0, 1, 0, 0, 4'd0);
        drive(0, 0, 1, 0, 0, 4'd0);
        check("b4_digits", 32'(s_digits), 32'h0);
        check("b4_count", 32'(s_count), 32'd0);
        drive(0, 0, 1, 0, 0, 4'd0);
        check("b5_digits", 32'(s_digits), 32'h0);
        check("b5_count", 32'(s_count), 32'd0);
`else
        drive(0, 0, 1, 0, 0, 4'd0);
        check("bx_digits", 32'(s_digits), 32'h0123);
        check("bx_count", 32'(s_count), 32'd3);
        drive(0, 0, 1, 1, 0, 4'd0);
        check("bx_enter_val", 32'(s_value), 32'h0123);
        check("bx_enter_vv", 32'(s_vv), 32'd1);
`endif

        drive(0, 0, 0, 1, 0, 4'd0);
        check("e0_value", 32'(s_value), 32'h0);
        check("e0_vv", 32'(s_vv), 32'd1);

        key(4); key(2);
        drive(0, 0, 0, 1, 0, 4'd0);
        check("e42_value", 32'(r_value), 32'h0042);
        key(7); key(8);
        check("mid_digits", 32'(r_digits), 32'h0078);
        drive(1, 0, 0, 0, 1, 4'd3);
        check("mr_digits", 32'(r_digits), 32'h0);
        check("mr_count", 32'(r_count), 32'd0);
        check("mr_value", 32'(r_value), 32'h0);
        check("mr_full", 32'(r_full), 32'd0);
        check("mr_err", 32'(r_err), 32'd0);
        check("mr_vv", 32'(r_vv), 32'd0);
        key(9);
        check("after_rst", 32'(s_digits), 32'h0009);
        check("after_rst_cnt", 32'(s_count), 32'd1);
        key(0);
        check("inner_zero", 32'(s_digits), 32'h0090);
        check("inner_zero_cnt", 32'(s_count), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
